// File: rtl/slc3_ctrl_pkg.sv
// Shared control encodings for the SLC3 control-flow sequencer: opcodes,
// datapath mux selects, sequencer states and the opcode dispatch rule.
package slc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JSR = 4'b0100;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    S_BEN,
    S_EVAL,
    S_TAKE,
    S_JMP,
    S_JSR,
    S_ILL,
    S_DONE
  } state_t;

  // First state of the sequence for a freshly accepted opcode.
  function automatic state_t dispatch(input logic [3:0] opcode);
    case (opcode)
      OP_BR:   return S_BEN;
      OP_JMP:  return S_JMP;
      OP_JSR:  return S_JSR;
      default: return S_ILL;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per inc strobe until the counter is full.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Control-flow sequencer for BR / JMP / RET / JSR / JSRR. Takes an instruction
// from the main ISDU via start, walks a short Moore FSM whose state decodes the
// datapath strobes, and hands control back with a done pulse. Also keeps
// saturating counts of evaluated and taken branches for the profiler.
module branch_sequencer
  import slc3_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [15:0]      IR,
  input  logic             BEN,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             LD_BEN,
  output logic             LD_PC,
  output logic             LD_REG,
  output logic             GatePC,
  output logic             DRMUX,
  output logic             SR1MUX,
  output logic             ADDR1MUX,
  output logic [1:0]       ADDR2MUX,
  output logic [1:0]       PCMUX,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] ir_q;
  logic        eval_cycle;

  // Only IR[11] (JSR vs JSRR) matters after dispatch; the remaining latched
  // bits are kept for debug visibility and folded into this sink.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[15:12], ir_q[10:0]};

  // State register and instruction latch; a new instruction is only taken in IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      ir_q      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        ir_q <= IR;
      end
    end
  end

  // Next-state logic and Moore decode of every strobe/select from the current state.
  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    illegal    = 1'b0;
    LD_BEN     = 1'b0;
    LD_PC      = 1'b0;
    LD_REG     = 1'b0;
    GatePC     = 1'b0;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    PCMUX      = PCMUX_PC1;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = dispatch(IR[15:12]);
        end
      end
      S_BEN: begin
        LD_BEN     = 1'b1;
        state_next = S_EVAL;
      end
      S_EVAL: begin
        state_next = BEN ? S_TAKE : S_DONE;
      end
      S_TAKE: begin
        LD_PC      = 1'b1;
        PCMUX      = PCMUX_ADDER;
        ADDR2MUX   = ADDR2_OFF9;
        state_next = S_DONE;
      end
      S_JMP: begin
        LD_PC      = 1'b1;
        PCMUX      = PCMUX_ADDER;
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        state_next = S_DONE;
      end
      S_JSR: begin
        // R7 <- PC and PC <- target on the same edge, so JSRR R7 uses old R7.
        GatePC = 1'b1;
        LD_REG = 1'b1;
        DRMUX  = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = PCMUX_ADDER;
        if (ir_q[11]) begin
          ADDR2MUX = ADDR2_OFF11;
        end else begin
          SR1MUX   = 1'b1;
          ADDR1MUX = 1'b1;
        end
        state_next = S_DONE;
      end
      S_ILL: begin
        done       = 1'b1;
        illegal    = 1'b1;
        state_next = IDLE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy       = (state_reg != IDLE);
  assign eval_cycle = (state_reg == S_EVAL);

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (eval_cycle),
    .count   (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (eval_cycle & BEN),
    .count   (taken_cnt)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: a default-width instance and a 2-bit-counter
// instance share all inputs. Expected strobes per cycle come from a table of
// what each instruction class must do at each cycle after start; expected
// counters come from plain integer tallies clipped to the counter width.
module tb_branch_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [15:0] IR;
  logic        BEN;

  logic        busy, done, illegal, LD_BEN, LD_PC, LD_REG, GatePC, DRMUX, SR1MUX, ADDR1MUX;
  logic [1:0]  ADDR2MUX, PCMUX;
  logic [15:0] branch_cnt, taken_cnt;

  logic        busy2, done2, illegal2, LD_BEN2, LD_PC2, LD_REG2, GatePC2, DRMUX2, SR1MUX2, ADDR1MUX2;
  logic [1:0]  ADDR2MUX2, PCMUX2;
  logic [1:0]  branch_cnt2, taken_cnt2;

  int checks = 0;
  int errors = 0;
  int br_n   = 0;
  int tk_n   = 0;

  branch_sequencer #(.CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .IR(IR), .BEN(BEN),
    .busy(busy), .done(done), .illegal(illegal), .LD_BEN(LD_BEN), .LD_PC(LD_PC),
    .LD_REG(LD_REG), .GatePC(GatePC), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .PCMUX(PCMUX),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_sequencer #(.CNT_W(2)) dut_small (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .IR(IR), .BEN(BEN),
    .busy(busy2), .done(done2), .illegal(illegal2), .LD_BEN(LD_BEN2), .LD_PC(LD_PC2),
    .LD_REG(LD_REG2), .GatePC(GatePC2), .DRMUX(DRMUX2), .SR1MUX(SR1MUX2),
    .ADDR1MUX(ADDR1MUX2), .ADDR2MUX(ADDR2MUX2), .PCMUX(PCMUX2),
    .branch_cnt(branch_cnt2), .taken_cnt(taken_cnt2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycles from start to the done pulse for one instruction.
  function automatic int latency(input logic [15:0] ir, input logic ben);
    case (ir[15:12])
      4'h0:    return ben ? 4 : 3;
      4'hC:    return 2;
      4'h4:    return 2;
      default: return 1;
    endcase
  endfunction

  // Required control outputs k cycles after start was accepted (k=0/after done: idle).
  function automatic logic [13:0] expect_ctrl(input logic [15:0] ir, input logic ben, input int k);
    logic b, d, il, lb, lp, lr, gp, dr, s1, a1;
    logic [1:0] a2, pm;
    int lat;
    lat = latency(ir, ben);
    {b, d, il, lb, lp, lr, gp, dr, s1, a1} = '0;
    a2 = 2'b00;
    pm = 2'b00;
    if (k >= 1 && k <= lat) b = 1'b1;
    if (k == lat) d = 1'b1;
    case (ir[15:12])
      4'h0: begin
        if (k == 1) lb = 1'b1;
        if (ben && k == 3) begin lp = 1'b1; a2 = 2'b10; pm = 2'b10; end
      end
      4'hC: if (k == 1) begin lp = 1'b1; s1 = 1'b1; a1 = 1'b1; pm = 2'b10; end
      4'h4: if (k == 1) begin
        gp = 1'b1; lr = 1'b1; dr = 1'b1; lp = 1'b1; pm = 2'b10;
        if (ir[11]) a2 = 2'b11;
        else begin s1 = 1'b1; a1 = 1'b1; end
      end
      default: if (k == 1) il = 1'b1;
    endcase
    return {b, d, il, lb, lp, lr, gp, dr, s1, a1, a2, pm};
  endfunction

  function automatic logic [13:0] observed_ctrl();
    return {busy, done, illegal, LD_BEN, LD_PC, LD_REG, GatePC, DRMUX, SR1MUX, ADDR1MUX, ADDR2MUX, PCMUX};
  endfunction

  function automatic int clip(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_branch_cnt"},  32'(branch_cnt),  32'(clip(br_n, 16)));
    chk({tag, "_taken_cnt"},   32'(taken_cnt),   32'(clip(tk_n, 16)));
    chk({tag, "_branch_cnt2"}, 32'(branch_cnt2), 32'(clip(br_n, 2)));
    chk({tag, "_taken_cnt2"},  32'(taken_cnt2),  32'(clip(tk_n, 2)));
  endtask

  // Issue one instruction from IDLE, disturb start/IR/BEN while busy, and check
  // every cycle through the return to IDLE plus the counters afterwards.
  task automatic run_instr(input logic [15:0] ir, input logic ben, input string tag);
    int lat;
    lat   = latency(ir, ben);
    IR    = ir;
    BEN   = ben;
    start = 1'b1;
    @(posedge Clk); #1;
    for (int k = 1; k <= lat + 1; k++) begin
      if (k <= lat) begin
        start = 1'($urandom_range(0, 1));
        IR    = 16'($urandom);
        BEN   = (ir[15:12] == 4'h0 && k == 2) ? ben : 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      chk($sformatf("%s_ctrl_k%0d", tag, k), 32'(observed_ctrl()), 32'(expect_ctrl(ir, ben, k)));
      if (k <= lat) begin
        @(posedge Clk); #1;
      end
    end
    if (ir[15:12] == 4'h0) begin
      br_n++;
      if (ben) tk_n++;
    end
    chk_counters(tag);
    $display("instr %s IR=%h BEN=%0d lat=%0d branch_cnt=%0d taken_cnt=%0d",
             tag, ir, ben, lat, branch_cnt, taken_cnt);
  endtask

  initial begin
    logic [15:0] rir;
    logic        rben;
    int          sel;

    Reset_n = 1'b0;
    start   = 1'b0;
    IR      = '0;
    BEN     = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_ctrl", 32'(observed_ctrl()), 32'd0);
    chk_counters("reset");
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    run_instr(16'h0E05, 1'b1, "br_taken");
    run_instr(16'h0805, 1'b0, "br_not_taken");

    // Abort a branch while it is evaluating BEN.
    IR = 16'h0E05; BEN = 1'b1; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    @(posedge Clk); #1;
    chk("abort_in_eval_state_busy", 32'(busy), 32'd1);
    Reset_n = 1'b0;
    br_n = 0;
    tk_n = 0;
    #1;
    chk("abort_ctrl_now", 32'(observed_ctrl()), 32'd0);
    chk_counters("abort");
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk("abort_ctrl_edge1", 32'(observed_ctrl()), 32'd0);
    @(posedge Clk); #1;
    chk("abort_ctrl_edge2", 32'(observed_ctrl()), 32'd0);
    chk_counters("abort_after");
    $display("instr abort IR=0e05 reset in eval branch_cnt=%0d taken_cnt=%0d", branch_cnt, taken_cnt);

    run_instr(16'hC1C0, 1'b0, "ret");
    run_instr(16'h4800, 1'b0, "jsr");
    run_instr(16'h41C0, 1'b1, "jsrr_r7");
    run_instr(16'h1021, 1'b1, "add_illegal");
    run_instr(16'h0005, 1'b1, "br_nzp000");

    for (int i = 0; i < 5; i++) begin
      run_instr(16'h0E05, 1'b1, $sformatf("sat_br%0d", i));
    end
    chk("sat_taken_small", 32'(taken_cnt2), 32'd3);

    for (int i = 0; i < 40; i++) begin
      sel  = int'($urandom_range(0, 3));
      rir  = 16'($urandom);
      rben = 1'($urandom_range(0, 1));
      case (sel)
        0: rir[15:12] = 4'h0;
        1: rir[15:12] = 4'hC;
        2: rir[15:12] = 4'h4;
        default: ;
      endcase
      run_instr(rir, rben, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
